// File: rtl/timer_pkg.sv
// Shared types and constants for the timer event controller.
package timer_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic {
    ONESHOT  = 1'b0,
    PERIODIC = 1'b1
  } tmode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } tstate_e;

endpackage

// File: rtl/timer_event_ctrl_gray4_to_bin.sv
// Combinational 4-bit Gray-to-binary converter, one per counter nibble.
module gray4_to_bin
  import timer_pkg::*;
(
  input  logic [NIB_W-1:0] gray_i,
  output logic [NIB_W-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_o[3] = gray_i[3];
    bin_o[2] = bin_o[3] ^ gray_i[2];
    bin_o[1] = bin_o[2] ^ gray_i[1];
    bin_o[0] = bin_o[1] ^ gray_i[0];
  end

endmodule

// File: rtl/timer_event_ctrl.sv
// Timer event controller: Gray-to-binary count register, compare-match IRQ
// with ack handshake, missed-IRQ flag and completed-period counter.
// Optional capture unit enabled by defining TIMER_CAPTURE_EN.
module timer_event_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W  = 20,
  parameter int unsigned PCNT_W = 8
) (
  input  logic              clk,
  input  logic              clr_n,
`ifdef TIMER_CAPTURE_EN
  input  logic              cap_in,
  output logic [CNT_W-1:0]  cap_val,
  output logic              cap_vld,
`endif
  input  logic [CNT_W-1:0]  cnt_gray,
  input  logic              tcc,
  input  logic [CNT_W-1:0]  cmp_val,
  input  logic              cmp_wr,
  input  logic              mode,
  input  logic              arm,
  input  logic              ack,
  output logic [CNT_W-1:0]  cnt_bin,
  output logic              match_pulse,
  output logic              irq,
  output logic              missed,
  output logic [PCNT_W-1:0] period_cnt,
  output logic [1:0]        state_o
);

  localparam int unsigned NNIB = CNT_W / NIB_W;

  logic [CNT_W-1:0]  cnt_bin_d;
  logic [CNT_W-1:0]  cnt_bin_q;
  logic [CNT_W-1:0]  cmp_q;
  logic              eq_d_q;
  logic              match_q;
  logic              irq_q;
  logic              missed_q;
  logic [PCNT_W-1:0] period_q;
  tstate_e           state_q;
  tmode_e            mode_c;
  logic              eq_c;
  logic              match_c;

  // Per-nibble Gray decode of the incoming count.
  for (genvar k = 0; k < NNIB; k++) begin : g_nib
    gray4_to_bin u_g2b (
      .gray_i (cnt_gray[k*NIB_W +: NIB_W]),
      .bin_o  (cnt_bin_d[k*NIB_W +: NIB_W])
    );
  end

  assign mode_c  = tmode_e'(mode);
  assign eq_c    = (cnt_bin_q == cmp_q);
  assign match_c = eq_c & ~eq_d_q & (state_q == ARMED);

  // Binary count, compare value and equality history; a compare write
  // clears the history so the new value can match immediately.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_bin_q <= '0;
      cmp_q     <= '0;
      eq_d_q    <= 1'b0;
    end else begin
      cnt_bin_q <= cnt_bin_d;
      if (cmp_wr) begin
        cmp_q  <= cmp_val;
        eq_d_q <= 1'b0;
      end else begin
        eq_d_q <= eq_c;
      end
    end
  end

  // Control FSM with match strobe, IRQ level and sticky missed flag.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      match_q  <= 1'b0;
      irq_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      match_q <= match_c;
      unique case (state_q)
        IDLE:    if (arm) state_q <= ARMED;
        ARMED:   if (match_c && (mode_c == ONESHOT)) state_q <= FIRED;
        FIRED:   if (ack) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // A match beats a simultaneous ack: the IRQ stays raised.
      if (match_c) begin
        irq_q <= 1'b1;
        if (irq_q && !ack) missed_q <= 1'b1;
        else if (ack)      missed_q <= 1'b0;
      end else if (ack) begin
        irq_q    <= 1'b0;
        missed_q <= 1'b0;
      end
    end
  end

  // Completed-period counter, free-wrapping.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      period_q <= '0;
    end else if (tcc) begin
      period_q <= period_q + PCNT_W'(1);
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]       cap_sync_q;
  logic             cap_edge_q;
  logic [CNT_W-1:0] cap_val_q;
  logic             cap_vld_q;

  // Synchronise cap_in, register its rising edge, latch the count on it.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cap_sync_q <= '0;
      cap_edge_q <= 1'b0;
      cap_val_q  <= '0;
      cap_vld_q  <= 1'b0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], cap_in};
      cap_edge_q <= cap_sync_q[1] & ~cap_sync_q[2];
      if (cap_edge_q) begin
        cap_val_q <= cnt_bin_q;
        cap_vld_q <= 1'b1;
      end else if (ack) begin
        cap_vld_q <= 1'b0;
      end
    end
  end

  assign cap_val = cap_val_q;
  assign cap_vld = cap_vld_q;
`endif

  assign cnt_bin     = cnt_bin_q;
  assign match_pulse = match_q;
  assign irq         = irq_q;
  assign missed      = missed_q;
  assign period_cnt  = period_q;
  assign state_o     = state_q;

endmodule
